mul_pipe_rv: RTL and testbench
==============================

Name: mul_pipe_rv

Overview:
- Parametrised, fully pipelined radix-8 Booth integer multiplier for the RV M-extension execute stage.
- Supports all four multiply ops (MUL, MULH, MULHSU, MULHU) with per-operand signedness.
- Uses valid/ready handshakes on both sides, a destination tag that travels alongside each operation, and a flush input.
- Accepts one operation per cycle; back-pressure stalls the pipeline without losing data.

Parameters:
- XLEN, 32: operand and result width; any even value ≥ 8.
- STAGES, 4: pipeline depth (register stages from input to output); legal range 2..8.
- TAG_W, 5: width of the tag carried alongside each operation (rd index).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts the operation this cycle
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (equal to funct3[1:0])
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  tag, returned unchanged on out_tag
- flush  in  1  kill all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  XLEN  selected half of the product
- out_tag  out  TAG_W  tag of the operation on out_result

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - all stage valid bits, out_valid, out_result and out_tag go to 0 immediately.
  - in_ready is 1 from the first cycle after reset release.
- Operand extension to XLEN+1 bits:
  - a is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - b is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- Product: P = ext(a) * ext(b), taken modulo 2^(2*XLEN).
  - MUL returns P[XLEN-1:0]; all other ops return P[2*XLEN-1:XLEN].
  - MUL's low half is the same for any signedness.
- Internal structure:
  - Radix-8 Booth encoding over ext(b), with ceil((XLEN+1)/3) partial products, each including the 3A term.
  - Partial products are sign-extended to 2*XLEN.
  - Reduction uses CSA levels, with a final adder in the last stage.
  - Combinational work may be split across stages freely; only the observable timing below is fixed.
- Handshake:
  - A transfer occurs when in_valid && in_ready on a rising edge; in_op, in_a, in_b and in_tag are sampled then.
  - The output fires when out_valid && out_ready.
  - out_result and out_tag are held stable while out_valid && !out_ready.
- Latency and throughput:
  - With no back-pressure, the result appears with out_valid=1 exactly STAGES cycles after acceptance.
  - Issue rate is 1 per cycle; results leave in acceptance order.
- Stall rule:
  - A stage advances if the next stage is empty or is itself advancing; the last stage advances on out_ready.
  - Bubbles collapse: in_ready = !(all stages valid && out_valid && !out_ready).
  - in_ready has no combinational dependence on in_valid.
- Flush:
  - On the edge where flush=1, every stage valid bit and out_valid clear.
  - An in_valid in the same cycle is not accepted (in_ready is forced to 0 while flush=1).
  - Flush has priority over out_ready; an output handshake in the flush cycle does not count as a transfer.
  - The data registers may keep stale values, but out_valid=0.
- Simultaneous events:
  - Output transfer and input acceptance in the same cycle with a full pipeline is legal; occupancy is unchanged.
  - Reset has priority over flush.
- Pipeline data registers are gated by each stage's advance enable (no toggling while stalled).

Test Plan:
- Reset then MUL a=0x0000_0007, b=0xFFFF_FFFD, tag=3 -> after 4 cycles out_valid=1, out_result=0xFFFF_FFEB, out_tag=3.
- MULH a=0x8000_0000, b=0x8000_0000 -> out_result=0x4000_0000; MUL with the same operands -> 0x0000_0000.
- MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF; MULHU with the same operands -> 0xFFFF_FFFE; MULH with the same operands -> 0x0000_0000.
- Back-to-back issue of 8 ops, tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles in tag order, each matching a software model.
- Same 8 ops with out_ready held 0 for 6 cycles mid-stream:
  - in_ready drops once 4 stages plus the output are occupied.
  - out_result holds stable while stalled.
  - No op is lost or duplicated.
- 3 ops in flight, flush=1 for one cycle together with in_valid=1 -> no out_valid for those ops; the next op issued afterwards returns in 4 cycles with the correct value. Assert rst_n=0 mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/mul_pipe_rv_if.sv
// Handshake bundle for the pipelined RV M-extension multiplier.
// The issuing side (execute stage) uses master; the multiplier uses slave.
interface mul_pipe_rv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_pipe_rv.sv
// Fully pipelined radix-8 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// STAGES register stages plus an output register; valid/ready with bubble collapse and flush.
module mul_pipe_rv #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  mul_pipe_rv_if.slave  bus
);

  localparam int W2  = 2 * XLEN;
  localparam int NPP = (XLEN + 3) / 3;
  localparam int BW  = 3 * NPP + 1;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  op_e op_in;
  logic a_sx, b_sx, take, in_ready;

  logic [STAGES:1]   v;
  logic [STAGES+1:1] en;

  logic [XLEN:0]      s1_a, s1_b;
  logic               s1_hi;
  logic [TAG_W-1:0]   s1_tag;

  logic [W2-1:0]      st_sum [2:STAGES];
  logic [W2-1:0]      st_car [2:STAGES];
  logic               st_hi  [2:STAGES];
  logic [TAG_W-1:0]   st_tag [2:STAGES];

  logic               out_valid_q;
  logic [XLEN-1:0]    out_result_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic [W2-1:0] a_w, a3, mult, pp, t, sum_c, car_c, prod;
  logic [BW-1:0] b_w;
  logic [3:0]    grp;
  logic [2:0]    m;
  logic [XLEN-1:0] res;

  assign op_in = op_e'(bus.in_op);
  assign a_sx  = (op_in != OP_MULHU);
  assign b_sx  = (op_in == OP_MUL) || (op_in == OP_MULH);

  // A stage may load when it is empty or its successor is loading; the
  // chain starts at the output register, which frees up on out_ready.
  always_comb begin
    en = '0;
    en[STAGES+1] = !out_valid_q || bus.out_ready;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      en[k] = !v[k] || en[k+1];
    end
  end

  assign in_ready = en[1] && !flush;
  assign take     = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v           <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      v           <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (en[STAGES+1]) out_valid_q <= v[STAGES];
      for (int unsigned k = STAGES; k >= 2; k--) begin
        if (en[k]) v[k] <= v[k-1];
      end
      if (en[1]) v[1] <= take;
    end
  end

  // Booth digit from bits {b[3i+2], b[3i+1], b[3i], b[3i-1]}; b_w[0] is the implicit b[-1].
  always_comb begin
    a_w   = {{(XLEN-1){s1_a[XLEN]}}, s1_a};
    a3    = a_w + (a_w << 1);
    b_w   = {BW{s1_b[XLEN]}};
    b_w[XLEN+1:0] = {s1_b, 1'b0};
    sum_c = '0;
    car_c = '0;
    grp   = '0;
    m     = '0;
    mult  = '0;
    pp    = '0;
    t     = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      grp = b_w[3*i +: 4];
      m   = grp[3] ? ~grp[2:0] : grp[2:0];
      case (m)
        3'd1, 3'd2: mult = a_w;
        3'd3, 3'd4: mult = a_w << 1;
        3'd5, 3'd6: mult = a3;
        3'd7:       mult = a_w << 2;
        default:    mult = '0;
      endcase
      pp    = grp[3] ? (~mult + W2'(1)) : mult;
      pp    = pp << (3 * i);
      t     = sum_c ^ car_c ^ pp;
      car_c = ((sum_c & car_c) | (sum_c & pp) | (car_c & pp)) << 1;
      sum_c = t;
    end
  end

  assign prod = st_sum[STAGES] + st_car[STAGES];
  assign res  = st_hi[STAGES] ? prod[W2-1:XLEN] : prod[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a         <= '0;
      s1_b         <= '0;
      s1_hi        <= 1'b0;
      s1_tag       <= '0;
      for (int unsigned k = 2; k <= STAGES; k++) begin
        st_sum[k] <= '0;
        st_car[k] <= '0;
        st_hi[k]  <= 1'b0;
        st_tag[k] <= '0;
      end
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      if (take) begin
        s1_a   <= {a_sx & bus.in_a[XLEN-1], bus.in_a};
        s1_b   <= {b_sx & bus.in_b[XLEN-1], bus.in_b};
        s1_hi  <= (op_in != OP_MUL);
        s1_tag <= bus.in_tag;
      end
      if (en[2] && v[1]) begin
        st_sum[2] <= sum_c;
        st_car[2] <= car_c;
        st_hi[2]  <= s1_hi;
        st_tag[2] <= s1_tag;
      end
      for (int unsigned k = 3; k <= STAGES; k++) begin
        if (en[k] && v[k-1]) begin
          st_sum[k] <= st_sum[k-1];
          st_car[k] <= st_car[k-1];
          st_hi[k]  <= st_hi[k-1];
          st_tag[k] <= st_tag[k-1];
        end
      end
      if (en[STAGES+1] && v[STAGES]) begin
        out_result_q <= res;
        out_tag_q    <= st_tag[STAGES];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_pipe_rv.sv
// Directed-vector bench for mul_pipe_rv: latency, op semantics, back-pressure, flush, async reset.
module tb_mul_pipe_rv;
  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;

  int checks   = 0;
  int failures = 0;

  vec_t vt [19];
  vec_t bb [8];

  mul_pipe_rv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_pipe_rv #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (op[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic present(input vec_t x);
    bus.in_op    = x.op;
    bus.in_a     = x.a;
    bus.in_b     = x.b;
    bus.in_tag   = x.tag;
    bus.in_valid = 1'b1;
  endtask

  // Called at a falling edge; issues one op and waits (bounded) for its result.
  task automatic run_single(input vec_t x, input string name);
    int lat;
    present(x);
    #1 chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, lat, STAGES);
    chk({name, ".result"}, bus.out_result, x.exp);
    chk({name, ".tag"}, 32'(bus.out_tag), 32'(x.tag));
    @(negedge clk);
    chk({name, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Streams bb[0..7] back to back; optionally holds out_ready low for 6 cycles.
  task automatic stream(input bit stall, input string name);
    bit saw_block;
    int got, first_fire, last_fire;
    saw_block  = 1'b0;
    got        = 0;
    first_fire = 0;
    last_fire  = 0;
    fork
      begin
        int i, guard;
        i = 0;
        guard = 0;
        while (i < 8 && guard < 40) begin
          @(negedge clk);
          guard++;
          present(bb[i]);
          #1;
          if (bus.in_ready) i++;
          else saw_block = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        int c, j;
        c = 0;
        j = 0;
        while (c < 40) begin
          @(negedge clk);
          c++;
          bus.out_ready = !(stall && c >= 3 && c <= 8);
          if (bus.out_valid) begin
            if (j < 8) begin
              chk($sformatf("%s.result%0d", name, j), bus.out_result, bb[j].exp);
              chk($sformatf("%s.tag%0d", name, j), 32'(bus.out_tag), 32'(bb[j].tag));
            end
            if (bus.out_ready) begin
              if (j == 0) first_fire = c;
              last_fire = c;
              j++;
            end
          end
        end
        got = j;
      end
    join
    bus.out_ready = 1'b1;
    chk({name, ".count"}, got, 8);
    chk({name, ".in_ready_dropped"}, 32'(saw_block), 32'(stall));
    if (!stall) chk({name, ".consecutive"}, last_fire - first_fire, 7);
  endtask

  initial begin
    int cnt;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    vt[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB};
    vt[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vt[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h0000_0000};
    vt[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
    vt[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE};
    vt[5]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000};
    vt[6]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'h0000_0001};
    vt[7]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFE};
    vt[8]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd9,  32'h3FFF_FFFF};
    vt[9]  = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd10, 32'h0000_0001};
    vt[10] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'hC000_0000};
    vt[11] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000};
    vt[12] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001};
    vt[13] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 5'd14, 32'hFFFE_0001};
    vt[14] = '{2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 5'd15, 32'h0000_0002};
    vt[15] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd31, 32'hFFFF_FFFF};
    vt[16] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0001};
    vt[17] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 5'd17, 32'h2345_6780};
    vt[18] = '{2'b11, 32'h1234_5678, 32'h0000_0010, 5'd18, 32'h0000_0001};

    for (int i = 0; i < 8; i++) begin
      bb[i].op  = 2'(i % 4);
      bb[i].a   = 32'hDEAD_BEEF ^ (32'(i) * 32'h0123_4567);
      bb[i].b   = 32'h8765_4321 + 32'(i) * 32'h1111_1111;
      bb[i].tag = 5'(i);
      bb[i].exp = model(bb[i].op, bb[i].a, bb[i].b);
    end

    repeat (2) @(negedge clk);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.out_result", bus.out_result, 32'd0);
    chk("reset.out_tag", 32'(bus.out_tag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 19; i++) run_single(vt[i], $sformatf("vec%0d", i));

    stream(1'b0, "b2b");
    stream(1'b1, "stall");

    // Flush with three ops in flight and a competing in_valid.
    for (int k = 0; k < 3; k++) begin
      present(vt[k]);
      @(negedge clk);
    end
    flush = 1'b1;
    present(vt[3]);
    #1 chk("flush.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    cnt = 0;
    repeat (10) begin
      if (bus.out_valid) cnt++;
      @(negedge clk);
    end
    chk("flush.killed", cnt, 0);
    run_single(vt[6], "post_flush");

    // Asynchronous reset while a result is held at the output.
    bus.out_ready = 1'b0;
    present(vt[0]);
    @(negedge clk);
    present(vt[1]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset.out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_reset.out_result", bus.out_result, vt[0].exp);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_reset.out_result", bus.out_result, 32'd0);
    chk("async_reset.out_tag", 32'(bus.out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset.out_valid", 32'(bus.out_valid), 32'd0);
    run_single(vt[13], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
